// File: rtl/tiny16_intc_pkg.sv
// tiny16_intc_pkg: controller state encoding and source index <-> CPU code mapping.
// Code 0 means "no interrupt"; source k is presented to the CPU as code k+1.
package tiny16_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam int CODE_NONE   = 0;
    localparam int CODE_OFFSET = 1;

    function automatic int index_to_code(input int idx);
        return idx + CODE_OFFSET;
    endfunction

    function automatic int code_to_index(input int code);
        return code - CODE_OFFSET;
    endfunction

endpackage

// File: rtl/tiny16_intc_edge.sv
// tiny16_intc_edge: per-source input conditioning and rising-edge detection.
// Optional feature macro: TINY16_INTC_SYNC_EN adds a two-flop synchronizer in
// front of the edge detector (irq-to-pending 3 cycles instead of 1).
module tiny16_intc_edge (
    input  logic clk,
    input  logic nreset,
    input  logic irq,
    output logic rise
);

    logic irq_cond;
    logic irq_hist;

`ifdef TINY16_INTC_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchronizer for an irq line asynchronous to clk
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= irq;
            sync_2 <= sync_1;
        end
    end

    assign irq_cond = sync_2;
`else
    assign irq_cond = irq;
`endif

    // Edge history; cleared on reset so a line already high at release counts as an edge
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irq_hist <= 1'b0;
        end else begin
            irq_hist <= irq_cond;
        end
    end

    assign rise = irq_cond & ~irq_hist;

endmodule

// File: rtl/tiny16_intc.sv
// tiny16_intc: fixed-priority, edge-triggered interrupt controller for the tiny16 CPU.
// Optional feature macro: TINY16_INTC_SYNC_EN (synchronize irq inputs, see tiny16_intc_edge).
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_IDLE    | nothing enabled pending; interrupt = 0
// ST_REQUEST | winning code presented on interrupt, re-evaluated every cycle
// ST_SERVICE | CPU in its handler; interrupt held 0, no nesting
module tiny16_intc
    import tiny16_intc_pkg::*;
#(
    parameter int                 INTERRUPT_BITS = 2,
    parameter int                 SOURCES        = 3,
    parameter logic [SOURCES-1:0] MASK_RESET     = '1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [SOURCES-1:0]        irq,
    input  logic                      mask_wr,
    input  logic [SOURCES-1:0]        mask_data,
    input  logic                      in_interrupt,
    output logic [INTERRUPT_BITS-1:0] interrupt,
    output logic [SOURCES-1:0]        pending,
    output logic [INTERRUPT_BITS-1:0] active
);

    if (SOURCES < 1 || SOURCES > (2**INTERRUPT_BITS) - 1) begin : g_bad_cfg
        $error("tiny16_intc: SOURCES must be in 1..(2**INTERRUPT_BITS)-1");
    end

    state_t                    state;
    state_t                    state_nxt;
    logic [SOURCES-1:0]        mask;
    logic [SOURCES-1:0]        rise;
    logic [SOURCES-1:0]        pend_en;
    logic [SOURCES-1:0]        ack_clr;
    logic [INTERRUPT_BITS-1:0] win_code;
    logic [INTERRUPT_BITS-1:0] interrupt_nxt;
    logic [INTERRUPT_BITS-1:0] active_nxt;
    logic                      ack;

    for (genvar k = 0; k < SOURCES; k++) begin : g_src
        tiny16_intc_edge u_edge (
            .clk    (clk),
            .nreset (nreset),
            .irq    (irq[k]),
            .rise   (rise[k])
        );
    end

    assign pend_en = pending & mask;

    // Lowest enabled pending index wins; scanning downward leaves the lowest last
    always_comb begin
        win_code = '0;
        for (int k = SOURCES - 1; k >= 0; k--) begin
            if (pend_en[k]) begin
                win_code = INTERRUPT_BITS'(index_to_code(k));
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; in_interrupt always takes precedence over new requests
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_interrupt) begin
                    state_nxt = ST_SERVICE;
                end else if (|pend_en) begin
                    state_nxt = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (in_interrupt) begin
                    state_nxt = ST_SERVICE;
                end else if (!(|pend_en)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (!in_interrupt) begin
                    state_nxt = (|pend_en) ? ST_REQUEST : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered interrupt/active codes and the ack strobe
    always_comb begin
        interrupt_nxt = '0;
        active_nxt    = active;
        ack           = 1'b0;
        case (state)
            ST_IDLE: begin
                // CPU-internal entry leaves active at 0 and acknowledges nothing
                active_nxt = '0;
                if (!in_interrupt) begin
                    interrupt_nxt = win_code;
                end
            end
            ST_REQUEST: begin
                if (in_interrupt) begin
                    // Acknowledge what the CPU actually saw, not the current winner
                    ack        = 1'b1;
                    active_nxt = interrupt;
                end else begin
                    interrupt_nxt = win_code;
                end
            end
            ST_SERVICE: begin
                if (!in_interrupt) begin
                    active_nxt    = '0;
                    interrupt_nxt = win_code;
                end
            end
            default: active_nxt = '0;
        endcase
    end

    // Decode the acknowledged code back to a one-hot pending clear
    always_comb begin
        ack_clr = '0;
        for (int k = 0; k < SOURCES; k++) begin
            if (ack && interrupt == INTERRUPT_BITS'(index_to_code(k))) begin
                ack_clr[k] = 1'b1;
            end
        end
    end

    // Pending latch: a same-cycle new edge beats the acknowledge clear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | rise;
        end
    end

    // Enable mask register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mask <= MASK_RESET;
        end else if (mask_wr) begin
            mask <= mask_data;
        end
    end

    // Registered CPU-facing codes
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            interrupt <= '0;
            active    <= '0;
        end else begin
            interrupt <= interrupt_nxt;
            active    <= active_nxt;
        end
    end

endmodule

// File: tb/tb_tiny16_intc.sv
// tb_tiny16_intc: scoreboard bench for tiny16_intc in its default build.
// Expectations are queued as stimulus is applied and drained one clock later.
module tb_tiny16_intc;
    import tiny16_intc_pkg::*;

    logic       clk;
    logic       nreset;
    logic [2:0] irq;
    logic       mask_wr;
    logic [2:0] mask_data;
    logic       in_interrupt;
    logic [1:0] interrupt;
    logic [2:0] pending;
    logic [1:0] active;

    int total = 0;
    int bad   = 0;

    typedef enum {S_INT, S_ACT, S_PEND, S_MASK, S_ST} sig_e;
    typedef struct {
        sig_e        sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    tiny16_intc dut (
        .clk          (clk),
        .nreset       (nreset),
        .irq          (irq),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .in_interrupt (in_interrupt),
        .interrupt    (interrupt),
        .pending      (pending),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_INT:   return 32'(interrupt);
            S_ACT:   return 32'(active);
            S_PEND:  return 32'(pending);
            S_MASK:  return 32'(dut.mask);
            default: return 32'(dut.state);
        endcase
    endfunction

    task automatic ex(input sig_e s, input string t, input logic [31:0] v);
        exp_t e;
        e.sel = s;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, sample(e.sel), e.val);
        end
    endtask

    // one rising edge, then compare everything queued for it
    task automatic cyc();
        @(negedge clk);
        drain();
    endtask

    initial begin
        irq          = 3'b000;
        mask_wr      = 1'b0;
        mask_data    = 3'b000;
        in_interrupt = 1'b0;
        nreset       = 1'b0;
        repeat (2) @(negedge clk);
        ex(S_INT,  "rst_int",  0);
        ex(S_ACT,  "rst_act",  0);
        ex(S_PEND, "rst_pend", 0);
        ex(S_MASK, "rst_mask", 3'b111);
        ex(S_ST,   "rst_st",   32'(ST_IDLE));
        drain();
        nreset = 1'b1;
        @(negedge clk);

        // single pulse on irq[1]
        irq = 3'b010;
        ex(S_PEND, "t1_pend", 3'b010);
        ex(S_INT,  "t1_int_a", 0);
        cyc();
        irq = 3'b000;
        ex(S_INT, "t1_int_b", 2);
        ex(S_ST,  "t1_req",   32'(ST_REQUEST));
        cyc();
        in_interrupt = 1'b1;
        ex(S_ACT,  "t1_act",   2);
        ex(S_PEND, "t1_clr",   0);
        ex(S_INT,  "t1_int_c", 0);
        cyc();
        in_interrupt = 1'b0;
        ex(S_ACT, "t1_act0", 0);
        ex(S_ST,  "t1_idle", 32'(ST_IDLE));
        cyc();

        // higher priority arrival replaces presented code
        irq = 3'b100;
        ex(S_PEND, "t2_p2", 3'b100);
        cyc();
        irq = 3'b001;
        ex(S_INT,  "t2_int3", 3);
        ex(S_PEND, "t2_p20",  3'b101);
        cyc();
        irq = 3'b000;
        ex(S_INT, "t2_int1", 1);
        cyc();
        in_interrupt = 1'b1;
        ex(S_ACT,  "t2_act",  1);
        ex(S_PEND, "t2_pend", 3'b100);
        ex(S_INT,  "t2_int0", 0);
        cyc();

        // no nesting during service
        irq = 3'b010;
        ex(S_PEND, "t3_pend",  3'b110);
        ex(S_INT,  "t3_int0",  0);
        cyc();
        irq = 3'b000;
        ex(S_INT, "t3_hold", 0);
        ex(S_ACT, "t3_act1", 1);
        cyc();
        in_interrupt = 1'b0;
        ex(S_ACT, "t3_act0", 0);
        ex(S_INT, "t3_int2", 2);
        cyc();

        // mask write withdraws the request
        mask_wr   = 1'b1;
        mask_data = 3'b000;
        ex(S_MASK, "t4_mask0",    0);
        ex(S_INT,  "t4_int_keep", 2);
        cyc();
        mask_wr = 1'b0;
        ex(S_INT,  "t4_int0", 0);
        ex(S_ST,   "t4_idle", 32'(ST_IDLE));
        ex(S_PEND, "t4_pend", 3'b110);
        cyc();
        mask_wr   = 1'b1;
        mask_data = 3'b111;
        ex(S_MASK, "t4_mask7", 3'b111);
        ex(S_INT,  "t4_int_z", 0);
        cyc();
        mask_wr = 1'b0;
        ex(S_INT, "t4_int2", 2);
        cyc();

        // mask write on the ack cycle: ack uses presented code
        in_interrupt = 1'b1;
        mask_wr      = 1'b1;
        mask_data    = 3'b011;
        ex(S_ACT,  "t4_ack_act",  2);
        ex(S_PEND, "t4_ack_pend", 3'b100);
        cyc();
        in_interrupt = 1'b0;
        mask_wr      = 1'b0;
        ex(S_ST,  "t4_idle2", 32'(ST_IDLE));
        ex(S_ACT, "t4_act0",  0);
        cyc();
        mask_wr   = 1'b1;
        mask_data = 3'b111;
        cyc();
        mask_wr = 1'b0;
        ex(S_INT, "t4_int3", 3);
        cyc();
        in_interrupt = 1'b1;
        ex(S_ACT,  "t4_act3",  3);
        ex(S_PEND, "t4_empty", 0);
        cyc();
        in_interrupt = 1'b0;
        ex(S_ST, "t4_idle3", 32'(ST_IDLE));
        cyc();

        // new edge on the ack cycle of the same source
        irq = 3'b001;
        ex(S_PEND, "t5_p", 3'b001);
        cyc();
        irq = 3'b000;
        ex(S_INT, "t5_int1", 1);
        cyc();
        in_interrupt = 1'b1;
        irq          = 3'b001;
        ex(S_PEND, "t5_setwins", 3'b001);
        ex(S_ACT,  "t5_act",     1);
        cyc();
        irq          = 3'b000;
        in_interrupt = 1'b0;
        ex(S_ACT, "t5_act0",  0);
        ex(S_INT, "t5_again", 1);
        cyc();
        in_interrupt = 1'b1;
        ex(S_PEND, "t5_clr",  0);
        ex(S_ACT,  "t5_act1", 1);
        cyc();
        in_interrupt = 1'b0;
        ex(S_ST, "t5_idle", 32'(ST_IDLE));
        cyc();

        // CPU-internal entry from IDLE clears nothing
        mask_wr   = 1'b1;
        mask_data = 3'b000;
        cyc();
        mask_wr = 1'b0;
        irq     = 3'b010;
        ex(S_PEND, "t6_p", 3'b010);
        ex(S_ST,   "t6_idle", 32'(ST_IDLE));
        cyc();
        irq          = 3'b000;
        in_interrupt = 1'b1;
        ex(S_ST,   "t6_svc",  32'(ST_SERVICE));
        ex(S_ACT,  "t6_act0", 0);
        ex(S_PEND, "t6_keep", 3'b010);
        cyc();
        mask_wr   = 1'b1;
        mask_data = 3'b111;
        cyc();
        mask_wr      = 1'b0;
        in_interrupt = 1'b0;
        ex(S_INT, "t6_int2", 2);
        ex(S_ACT, "t6_act",  0);
        cyc();

        // async reset in the middle of a service
        in_interrupt = 1'b1;
        ex(S_ACT, "t7_act2", 2);
        cyc();
        irq = 3'b001;
        ex(S_PEND, "t7_p", 3'b001);
        cyc();
        irq       = 3'b000;
        mask_wr   = 1'b1;
        mask_data = 3'b010;
        ex(S_MASK, "t7_mask", 3'b010);
        cyc();
        mask_wr      = 1'b0;
        in_interrupt = 1'b0;
        irq          = 3'b010;
        #3 nreset = 1'b0;
        #1;
        ex(S_INT,  "t7_int",  0);
        ex(S_ACT,  "t7_act",  0);
        ex(S_PEND, "t7_pend", 0);
        ex(S_MASK, "t7_mask7", 3'b111);
        ex(S_ST,   "t7_st",   32'(ST_IDLE));
        drain();

        // edge present on the first clock after release
        @(negedge clk);
        nreset = 1'b1;
        ex(S_PEND, "t8_first", 3'b010);
        cyc();
        irq = 3'b000;
        ex(S_INT, "t8_int2", 2);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tiny16_intc.md
TINY16_INTC -- requirements
Module: tiny16_intc

Interface
REQ-001 SHALL have parameter INTERRUPT_BITS, default 2: width of the code driven into the CPU interrupt input.
REQ-002 SHALL have parameter SOURCES, default 3: number of interrupt sources; legal range 1..(2**INTERRUPT_BITS)-1.
REQ-003 SHALL have parameter MASK_RESET, default all ones: reset value of the enable mask.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port nreset, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port irq, input, SOURCES: source request lines, rising-edge triggered.
REQ-007 SHALL have port mask_wr, input, 1: mask write strobe.
REQ-008 SHALL have port mask_data, input, SOURCES: new mask value; 1 = enabled.
REQ-009 SHALL have port in_interrupt, input, 1: CPU in-service flag; the CPU sets it when it takes an interrupt and clears it on reti.
REQ-010 SHALL have port interrupt, output, INTERRUPT_BITS: registered code to the CPU; 0 = none, k+1 = source k.
REQ-011 SHALL have port pending, output, SOURCES: latched pending bits.
REQ-012 SHALL have port active, output, INTERRUPT_BITS: code currently in service; 0 when idle.

Function
REQ-013 SHALL set pending[k] one cycle after a 0->1 transition is detected on the conditioned irq[k].
REQ-014 SHALL keep pending[k] set until that source is acknowledged, regardless of mask state.
REQ-015 SHALL use fixed priority among pending & mask: the lowest index wins.
REQ-016 SHALL implement a state machine with states IDLE, REQUEST and SERVICE.
REQ-017 In IDLE, SHALL drive interrupt=0 and enter REQUEST when pending & mask is nonzero.
REQ-018 In REQUEST, SHALL register the code of the winning source each cycle, so a higher-priority arrival replaces the presented code before acknowledge.
REQ-019 In REQUEST, SHALL return to IDLE with interrupt=0 when pending & mask becomes zero (e.g. via a mask write).
REQ-020 On a REQUEST cycle that samples in_interrupt=1, SHALL (a) copy the presented interrupt value to active, (b) clear pending[active-1], (c) drive interrupt=0, and (d) enter SERVICE.
REQ-021 In SERVICE, SHALL hold interrupt=0 (no nesting) and keep accumulating new pending bits.
REQ-022 SHALL leave SERVICE when in_interrupt=0 is sampled: active becomes 0, then the block enters REQUEST if pending & mask is nonzero, else IDLE.
REQ-023 If in_interrupt=1 is sampled while in IDLE (CPU-internal entry), SHALL enter SERVICE with active=0 and clear no pending bit.
REQ-024 On a new edge on source k in the same cycle that source k is acknowledged, SHALL leave pending[k] set (the set wins).
REQ-025 On mask_wr in the same cycle as an acknowledge, SHALL base the acknowledge on the code already presented; the new mask takes effect from the next cycle.
REQ-026 SHALL make a mask write visible on the mask one cycle after the strobe.

Reset
REQ-027 While nreset=0, SHALL asynchronously force state=IDLE, interrupt=0, active=0, pending=0, mask=MASK_RESET and edge history=0.
REQ-028 SHALL accept an edge detected on the first clock after reset release normally.
REQ-029 SHALL treat a reset asserted mid-SERVICE as an abort: no pending bits are restored.

Configuration
REQ-030 With TINY16_INTC_SYNC_EN defined, SHALL pass each irq bit through a two-flop synchronizer before edge detection; irq-to-pending latency is 3 cycles.
REQ-031 Without TINY16_INTC_SYNC_EN, SHALL treat irq as synchronous to clk; irq-to-pending latency is 1 cycle.

Structure
REQ-032 SHALL place the state encoding and the code/index conversion constants in package tiny16_intc_pkg.
REQ-033 SHALL implement synchronizer and edge detection per source in sub-module tiny16_intc_edge, instantiated SOURCES times.
REQ-034 SHALL report an elaboration error if SOURCES > (2**INTERRUPT_BITS)-1.

Verification
REQ-035 Bench SHALL check: irq[1] pulse, no SYNC_EN -> pending=3'b010 after 1 cycle, interrupt=2 after 2 cycles.
REQ-036 Bench SHALL check: irq[2] then irq[0] one cycle later, before ack -> interrupt changes 3 then 1; in_interrupt=1 -> active=1, pending=3'b100.
REQ-037 Bench SHALL check: in SERVICE with active=1, irq[1] edge -> interrupt stays 0; in_interrupt falls -> active=0, then interrupt=2.
REQ-038 Bench SHALL check: mask_data=3'b000 written while interrupt=2 -> interrupt=0, IDLE, pending retained; mask restored -> interrupt=2.
REQ-039 Bench SHALL check: irq[0] edge on the ack cycle of source 0 -> pending[0]=1 after ack.
REQ-040 Bench SHALL check: nreset pulled low mid-SERVICE, asynchronous to clk -> all outputs 0 immediately, mask=3'b111.
